// File: rtl/mul8_sequencer.sv
// 8x8 unsigned multiplier sequenced over a shared 4x4 array multiplier.
// Four partial products are accumulated, one per cycle, then the result is registered.
module mul8_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic [3:0]  mul_a,
   output logic [3:0]  mul_b,
   input  logic [7:0]  mul_p
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PP0  = 3'd1,
      PP1  = 3'd2,
      PP2  = 3'd3,
      PP3  = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state;
   logic [7:0]  ra;
   logic [7:0]  rb;
   logic [15:0] acc;

   // Sequencer: state, operands, accumulator and all outputs are registered here
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         ra      <= 8'h00;
         rb      <= 8'h00;
         acc     <= 16'h0000;
         product <= 16'h0000;
         busy    <= 1'b0;
         done    <= 1'b0;
         mul_a   <= 4'h0;
         mul_b   <= 4'h0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               mul_a <= 4'h0;
               mul_b <= 4'h0;
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  acc   <= 16'h0000;
                  busy  <= 1'b1;
                  mul_a <= a[3:0];
                  mul_b <= b[3:0];
                  state <= PP0;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            PP0: begin
               acc   <= acc + {8'h00, mul_p};
               mul_a <= ra[7:4];
               mul_b <= rb[3:0];
               state <= PP1;
            end
            PP1: begin
               acc   <= acc + {4'h0, mul_p, 4'h0};
               mul_a <= ra[3:0];
               mul_b <= rb[7:4];
               state <= PP2;
            end
            PP2: begin
               acc   <= acc + {4'h0, mul_p, 4'h0};
               mul_a <= ra[7:4];
               mul_b <= rb[7:4];
               state <= PP3;
            end
            PP3: begin
               product <= acc + {mul_p, 8'h00};
               busy    <= 1'b0;
               done    <= 1'b1;
               mul_a   <= 4'h0;
               mul_b   <= 4'h0;
               state   <= DONE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               mul_a <= 4'h0;
               mul_b <= 4'h0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul8_sequencer.sv
// Bench for mul8_sequencer: behavioural 4x4 multiplier on mul_p,
// expected products queued at issue and checked on each done pulse.
module tb_mul8_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic [7:0]  mul_p;

   int checks   = 0;
   int failures = 0;
   logic [15:0] sb[$];
   logic [3:0]  seq_a[4];
   logic [3:0]  seq_b[4];

   mul8_sequencer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .mul_a   (mul_a),
      .mul_b   (mul_b),
      .mul_p   (mul_p)
   );

   assign mul_p = mul_a * mul_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: product %h, none expected", product);
         end else begin
            logic [15:0] e;
            e = sb.pop_front();
            if (product !== e) begin
               failures++;
               $display("FAIL sb_product: got %h expected %h", product, e);
            end
         end
      end
   end

   // Issue one isolated operation and walk it through PP0..PP3 and DONE
   task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                         input string tag);
      a = x;
      b = y;
      start = 1'b1;
      sb.push_back(16'(x) * 16'(y));
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
         chk({tag, "_nodone"}, {15'd0, done}, 16'd0);
         seq_a[i] = mul_a;
         seq_b[i] = mul_b;
         step();
      end
      chk({tag, "_done"}, {15'd0, done}, 16'd1);
      chk({tag, "_busy_off"}, {15'd0, busy}, 16'd0);
      chk({tag, "_prod"}, product, 16'(x) * 16'(y));
      chk({tag, "_mul_a_done"}, {12'd0, mul_a}, 16'd0);
      step();
      chk({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
   endtask

   initial begin
      logic [3:0] exp_a[4];
      logic [3:0] exp_b[4];
      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      repeat (2) step();
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_product", product, 16'h0000);
      chk("rst_mul_a", {12'd0, mul_a}, 16'd0);
      chk("rst_mul_b", {12'd0, mul_b}, 16'd0);
      rst_n = 1'b1;
      step();

      run_op(8'hFF, 8'hFF, "ffxff");
      chk("ffxff_val", product, 16'hFE01);

      run_op(8'h12, 8'h34, "12x34");
      chk("12x34_val", product, 16'h03A8);
      exp_a = '{4'h2, 4'h1, 4'h2, 4'h1};
      exp_b = '{4'h4, 4'h4, 4'h3, 4'h3};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("seq_a%0d", i), {12'd0, seq_a[i]}, {12'd0, exp_a[i]});
         chk($sformatf("seq_b%0d", i), {12'd0, seq_b[i]}, {12'd0, exp_b[i]});
      end

      // Back-to-back with start held high
      a = 8'h0F;
      b = 8'h10;
      start = 1'b1;
      sb.push_back(16'h00F0);
      step();
      a = 8'hA5;
      b = 8'h03;
      sb.push_back(16'h01EF);
      repeat (4) step();
      chk("b2b1_done", {15'd0, done}, 16'd1);
      chk("b2b1_prod", product, 16'h00F0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("b2b_hold", product, 16'h00F0);
         chk("b2b_busy", {15'd0, busy}, 16'd1);
         step();
      end
      chk("b2b2_done", {15'd0, done}, 16'd1);
      chk("b2b2_prod", product, 16'h01EF);
      start = 1'b0;
      step();
      chk("b2b_idle", {15'd0, busy | done}, 16'd0);

      // start pulsed in PP1 is ignored
      a = 8'h07;
      b = 8'h09;
      start = 1'b1;
      sb.push_back(16'h003F);
      step();
      start = 1'b0;
      step();
      a = 8'hFF;
      b = 8'hFF;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      chk("ign_done", {15'd0, done}, 16'd1);
      chk("ign_prod", product, 16'h003F);
      step();

      // Reset in PP2 aborts, with start asserted alongside
      a = 8'h55;
      b = 8'h66;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      chk("abort_in_pp", {15'd0, busy}, 16'd1);
      rst_n = 1'b0;
      start = 1'b1;
      step();
      rst_n = 1'b1;
      start = 1'b0;
      chk("abort_busy", {15'd0, busy}, 16'd0);
      chk("abort_done", {15'd0, done}, 16'd0);
      chk("abort_prod", product, 16'h0000);
      chk("abort_mul", {8'd0, mul_a, mul_b}, 16'd0);
      repeat (6) begin
         chk("abort_no_done", {15'd0, done}, 16'd0);
         step();
      end
      run_op(8'h80, 8'h02, "80x02");
      chk("80x02_val", product, 16'h0100);

      // Random pairs back-to-back
      start = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         sb.push_back(16'(a) * 16'(b));
         step();
         repeat (4) step();
      end
      start = 1'b0;
      repeat (3) step();
      chk("sb_drained", 16'(sb.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
